pc_sequencer: RTL and testbench

Parametrised program-counter unit for the processor datapath. It replaces the fixed 16-bit PC register and its increment/load mux. Adds relative branches, flag-conditional jumps/branches and call/return through an internal return-address stack (RAS). It sits between the controller (op, enable) and the instruction memory address port, and consumes the ALU flags.

---
 rtl/pc_seq_pkg.sv | 41 ++++
 rtl/ras_lifo.sv | 53 +++++
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: operations, condition
// codes and ALU flag bit positions.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'd0,
        OP_JABS  = 3'd1,
        OP_BREL  = 3'd2,
        OP_JCOND = 3'd3,
        OP_BCOND = 3'd4,
        OP_CALL  = 3'd5,
        OP_RET   = 3'd6,
        OP_HOLD  = 3'd7
    } op_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0,
        CC_NE = 4'h1,
        CC_CS = 4'h2,
        CC_CC = 4'h3,
        CC_HI = 4'h4,
        CC_LS = 4'h5,
        CC_GT = 4'h6,
        CC_LE = 4'h7,
        CC_FS = 4'h8,
        CC_FC = 4'h9,
        CC_LO = 4'hA,
        CC_HS = 4'hB,
        CC_LT = 4'hC,
        CC_GE = 4'hD,
        CC_AL = 4'hE,
        CC_NV = 4'hF
    } cc_e;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/ras_lifo.sv
// Return-address stack: LIFO with a registered occupancy count. Pushes on a
// full stack and pops on an empty stack are ignored.
module ras_lifo
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [AW-1:0]    w_top_idx;

    // Occupancy count; synchronous active-low reset empties the stack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (push && !full) begin
            r_count <= r_count + CNT_W'(1);
        end else if (pop && !empty) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Storage write; the slot at index count is the next free entry.
    always_ff @(posedge clk) begin
        if (reset && push && !full) begin
            r_mem[r_count[AW-1:0]] <= din;
        end
    end

    assign w_top_idx = r_count[AW-1:0] - AW'(1);
    assign dout      = r_mem[w_top_idx];
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == {CNT_W{1'b0}});
    assign count     = r_count;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with relative/conditional branches and call/return
// through a return-address stack. Define PC_SEQ_TRAP_EN to vector RAS faults to TRAP_VEC.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              DISP_W    = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}},
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(16'hFFF0)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic [2:0]        op,
    input  logic [3:0]        cond,
    input  logic [4:0]        flags,
    input  logic [PC_W-1:0]   target,
    input  logic [DISP_W-1:0] disp,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus1,
    output logic              taken,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
);

`ifdef PC_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [PC_W-1:0]  r_pc;
    logic             r_taken;
    logic             r_ras_err;

    logic [PC_W-1:0]  w_pc_plus1;
    logic [PC_W-1:0]  w_pc_brel;
    logic [PC_W-1:0]  w_next_pc;
    logic             w_next_taken;
    logic             w_fault;
    logic             w_cond_true;
    logic             w_push;
    logic             w_pop;
    logic [PC_W-1:0]  w_ras_dout;
    logic             w_ras_full;
    logic             w_ras_empty;
    logic [CNT_W-1:0] w_ras_count;

    wire w_c = flags[FLAG_C];
    wire w_l = flags[FLAG_L];
    wire w_f = flags[FLAG_F];
    wire w_z = flags[FLAG_Z];
    wire w_n = flags[FLAG_N];

    assign w_pc_plus1 = r_pc + PC_W'(1);
    assign w_pc_brel  = r_pc + PC_W'($signed(disp));

    // Condition-code evaluation against the ALU flags.
    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            CC_EQ:   w_cond_true = w_z;
            CC_NE:   w_cond_true = !w_z;
            CC_CS:   w_cond_true = w_c;
            CC_CC:   w_cond_true = !w_c;
            CC_HI:   w_cond_true = w_l;
            CC_LS:   w_cond_true = !w_l;
            CC_GT:   w_cond_true = w_n;
            CC_LE:   w_cond_true = !w_n;
            CC_FS:   w_cond_true = w_f;
            CC_FC:   w_cond_true = !w_f;
            CC_LO:   w_cond_true = !w_l && !w_z;
            CC_HS:   w_cond_true = w_l || w_z;
            CC_LT:   w_cond_true = !w_n && !w_z;
            CC_GE:   w_cond_true = w_n || w_z;
            CC_AL:   w_cond_true = 1'b1;
            CC_NV:   w_cond_true = 1'b0;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Next-PC selection and stack control for the current op.
    always_comb begin
        w_next_pc    = r_pc;
        w_next_taken = 1'b0;
        w_fault      = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (op)
            OP_NEXT: w_next_pc = w_pc_plus1;
            OP_JABS: begin
                w_next_pc    = target;
                w_next_taken = 1'b1;
            end
            OP_BREL: begin
                w_next_pc    = w_pc_brel;
                w_next_taken = 1'b1;
            end
            OP_JCOND: begin
                w_next_pc    = w_cond_true ? target : w_pc_plus1;
                w_next_taken = w_cond_true;
            end
            OP_BCOND: begin
                w_next_pc    = w_cond_true ? w_pc_brel : w_pc_plus1;
                w_next_taken = w_cond_true;
            end
            OP_CALL: begin
                w_next_taken = 1'b1;
                if (w_ras_full) begin
                    w_fault   = 1'b1;
                    w_next_pc = TRAP_EN ? TRAP_VEC : target;
                end else begin
                    w_push    = pc_en;
                    w_next_pc = target;
                end
            end
            OP_RET: begin
                if (w_ras_count == {CNT_W{1'b0}}) begin
                    w_fault      = 1'b1;
                    w_next_pc    = TRAP_EN ? TRAP_VEC : w_pc_plus1;
                    w_next_taken = TRAP_EN;
                end else begin
                    w_pop        = pc_en;
                    w_next_pc    = w_ras_dout;
                    w_next_taken = 1'b1;
                end
            end
            OP_HOLD: w_next_pc = r_pc;
            default: w_next_pc = r_pc;
        endcase
    end

    // PC, taken and sticky fault flag; everything holds while pc_en is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc      <= RESET_VEC;
            r_taken   <= 1'b0;
            r_ras_err <= 1'b0;
        end else if (pc_en) begin
            r_pc      <= w_next_pc;
            r_taken   <= w_next_taken;
            r_ras_err <= r_ras_err | w_fault;
        end else begin
            r_pc      <= r_pc;
            r_taken   <= r_taken;
            r_ras_err <= r_ras_err;
        end
    end

    ras_lifo #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_plus1),
        .dout  (w_ras_dout),
        .full  (w_ras_full),
        .empty (w_ras_empty),
        .count (w_ras_count)
    );

    assign pc        = r_pc;
    assign pc_plus1  = w_pc_plus1;
    assign taken     = r_taken;
    assign ras_full  = w_ras_full;
    assign ras_empty = w_ras_empty;
    assign ras_err   = r_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [3:0]  cond = 4'd0;
    logic [4:0]  flags = 5'd0;
    logic [15:0] target = 16'h0000;
    logic [7:0]  disp = 8'h00;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        taken;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_err;

    pc_sequencer #(
        .PC_W      (16),
        .DISP_W    (8),
        .RAS_DEPTH (4),
        .RESET_VEC (16'h0010),
        .TRAP_VEC  (16'hFFF0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_en     (pc_en),
        .op        (op),
        .cond      (cond),
        .flags     (flags),
        .target    (target),
        .disp      (disp),
        .pc        (pc),
        .pc_plus1  (pc_plus1),
        .taken     (taken),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] pcp1;
        logic        taken;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    logic [15:0] m_pc = 16'h0000;
    logic        m_taken = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_stack[$];

    function automatic bit cond_holds(input logic [3:0] c, input logic [4:0] f);
        bit cf = f[4];
        bit lf = f[3];
        bit ff = f[2];
        bit zf = f[1];
        bit nf = f[0];
        case (c)
            4'h0: return zf;
            4'h1: return !zf;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return lf;
            4'h5: return !lf;
            4'h6: return nf;
            4'h7: return !nf;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !lf && !zf;
            4'hB: return lf || zf;
            4'hC: return !nf && !zf;
            4'hD: return nf || zf;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input logic rn, input logic en, input logic [2:0] o,
                              input logic [3:0] c, input logic [4:0] f,
                              input logic [15:0] t, input logic [7:0] d);
        logic [15:0] sdisp;
        bit trap_en;
`ifdef PC_SEQ_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        sdisp = {{8{d[7]}}, d};
        if (!rn) begin
            m_pc = 16'h0010;
            m_taken = 1'b0;
            m_err = 1'b0;
            m_stack.delete();
        end else if (en) begin
            case (o)
                3'd0: begin m_pc = m_pc + 16'd1; m_taken = 1'b0; end
                3'd1: begin m_pc = t; m_taken = 1'b1; end
                3'd2: begin m_pc = m_pc + sdisp; m_taken = 1'b1; end
                3'd3: begin
                    m_taken = cond_holds(c, f);
                    m_pc = m_taken ? t : m_pc + 16'd1;
                end
                3'd4: begin
                    m_taken = cond_holds(c, f);
                    m_pc = m_taken ? m_pc + sdisp : m_pc + 16'd1;
                end
                3'd5: begin
                    m_taken = 1'b1;
                    if (m_stack.size() == 4) begin
                        m_err = 1'b1;
                        m_pc = trap_en ? 16'hFFF0 : t;
                    end else begin
                        m_stack.push_back(m_pc + 16'd1);
                        m_pc = t;
                    end
                end
                3'd6: begin
                    if (m_stack.size() == 0) begin
                        m_err = 1'b1;
                        m_pc = trap_en ? 16'hFFF0 : m_pc + 16'd1;
                        m_taken = trap_en;
                    end else begin
                        m_pc = m_stack.pop_back();
                        m_taken = 1'b1;
                    end
                end
                default: m_taken = 1'b0;
            endcase
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected response.
    task automatic drive(input logic rn, input logic en, input logic [2:0] o,
                         input logic [3:0] c, input logic [4:0] f,
                         input logic [15:0] t, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        reset = rn; pc_en = en; op = o; cond = c; flags = f; target = t; disp = d;
        model_step(rn, en, o, c, f, t, d);
        e.pc    = m_pc;
        e.pcp1  = m_pc + 16'd1;
        e.taken = m_taken;
        e.full  = (m_stack.size() == 4);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc",        pc,                e.pc);
            chk("pc_plus1",  pc_plus1,          e.pcp1);
            chk("taken",     {15'd0, taken},    {15'd0, e.taken});
            chk("ras_full",  {15'd0, ras_full}, {15'd0, e.full});
            chk("ras_empty", {15'd0, ras_empty},{15'd0, e.empty});
            chk("ras_err",   {15'd0, ras_err},  {15'd0, e.err});
        end
    end

    initial begin
        logic [2:0] r_op;
        // Reset then hold with pc_en low
        drive(1'b0, 1'b1, 3'd5, 4'h0, 5'h00, 16'h1234, 8'h00);
        drive(1'b0, 1'b0, 3'd0, 4'h0, 5'h00, 16'h0000, 8'h00);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 3'($urandom_range(0, 7)), 4'h0, 5'h00, 16'h5555, 8'h11);
        // Sequential wrap
        drive(1'b1, 1'b1, 3'd1, 4'h0, 5'h00, 16'hFFFE, 8'h00);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 3'd0, 4'h0, 5'h00, 16'h0000, 8'h00);
        // Branches
        drive(1'b1, 1'b1, 3'd1, 4'h0, 5'h00, 16'h0100, 8'h00);
        drive(1'b1, 1'b1, 3'd2, 4'h0, 5'h00, 16'h0000, 8'hFE);
        drive(1'b1, 1'b1, 3'd3, 4'h0, 5'h00, 16'h0400, 8'h00);
        drive(1'b1, 1'b1, 3'd3, 4'h0, 5'h02, 16'h0400, 8'h00);
        drive(1'b1, 1'b1, 3'd1, 4'h0, 5'h00, 16'h0002, 8'h00);
        drive(1'b1, 1'b1, 3'd4, 4'hE, 5'h00, 16'h0000, 8'hFC);
        // Call / return
        drive(1'b0, 1'b1, 3'd0, 4'h0, 5'h00, 16'h0000, 8'h00);
        drive(1'b1, 1'b1, 3'd5, 4'h0, 5'h00, 16'h0200, 8'h00);
        drive(1'b1, 1'b1, 3'd5, 4'h0, 5'h00, 16'h0300, 8'h00);
        drive(1'b1, 1'b1, 3'd6, 4'h0, 5'h00, 16'h0000, 8'h00);
        drive(1'b1, 1'b1, 3'd6, 4'h0, 5'h00, 16'h0000, 8'h00);
        // Faults: overflow then drain and underflow
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b1, 3'd5, 4'h0, 5'h00, 16'h1000 + 16'(i * 16), 8'h00);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b1, 3'd6, 4'h0, 5'h00, 16'h0000, 8'h00);
        // Reset on the same edge as a CALL
        drive(1'b1, 1'b1, 3'd5, 4'h0, 5'h00, 16'h0777, 8'h00);
        drive(1'b0, 1'b1, 3'd5, 4'h0, 5'h00, 16'h0888, 8'h00);
        drive(1'b1, 1'b1, 3'd0, 4'h0, 5'h00, 16'h0000, 8'h00);
        // Randomized traffic, biased toward stack activity
        for (int i = 0; i < 600; i++) begin
            r_op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) r_op = ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd6;
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0), r_op,
                  4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                  16'($urandom), 8'($urandom));
        end
        drive(1'b1, 1'b0, 3'd7, 4'h0, 5'h00, 16'h0000, 8'h00);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
